// File: rtl/gh_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gh_pkg
// Brief    : Shared constants, judge FSM state type and popcount helper for
//            the note track judging logic.
// Revision : 1.0 - initial release
// ============================================================================
package gh_pkg;

    localparam int LANES    = 4;
    localparam int SCORE_W  = 16;
    localparam int STREAK_W = 8;
    localparam int MULT2_AT = 8;
    localparam int MULT4_AT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OPEN = 1'b1
    } judge_state_t;

    // Lane vectors are zero-extended to 32 bits so one helper serves any LANES.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_hit_judge_if.sv
`default_nettype none
// ============================================================================
// Module   : note_hit_judge_if
// Brief    : Track/button inputs and score/strobe outputs of the hit judge.
// Revision : 1.0 - initial release
// ============================================================================
interface note_hit_judge_if #(
    parameter int LANES    = gh_pkg::LANES,
    parameter int SCORE_W  = gh_pkg::SCORE_W,
    parameter int STREAK_W = gh_pkg::STREAK_W
) ();

    logic                TICK;
    logic [LANES-1:0]    NOTE_IN;
    logic [LANES-1:0]    KEY_N;
    logic                ENABLE;
    logic [SCORE_W-1:0]  SCORE;
    logic [STREAK_W-1:0] STREAK;
    logic [2:0]          MULT;
    logic [LANES-1:0]    PENDING;
    logic                HIT;
    logic                MISS;

    modport master (
        output TICK, NOTE_IN, KEY_N, ENABLE,
        input  SCORE, STREAK, MULT, PENDING, HIT, MISS
    );

    modport slave (
        input  TICK, NOTE_IN, KEY_N, ENABLE,
        output SCORE, STREAK, MULT, PENDING, HIT, MISS
    );

endinterface
`default_nettype wire

// File: rtl/key_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : key_edge_sync
// Brief    : Active-low button synchronizer with registered rising-edge
//            (press) detect; pin-to-press latency is 3 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module key_edge_sync #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_GAME,
    input  logic [WIDTH-1:0] i_key_n,
    output logic [WIDTH-1:0] o_press
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_press;

    // Reset value 0 means "released" after inversion of the active-low pins.
    always_ff @(posedge CLK) begin
        if (RESET_GAME) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_press <= '0;
        end else begin
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_press <= r_sync2 & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/note_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : note_hit_judge
// Brief    : Judges lane presses against the strike-zone row; produces hit/miss
//            strobes, streak, multiplier and a saturating score.
// Revision : 1.0 - initial release
// ============================================================================
module note_hit_judge
    import gh_pkg::*;
#(
    parameter int LANES    = gh_pkg::LANES,
    parameter int SCORE_W  = gh_pkg::SCORE_W,
    parameter int STREAK_W = gh_pkg::STREAK_W,
    parameter int MULT2_AT = gh_pkg::MULT2_AT,
    parameter int MULT4_AT = gh_pkg::MULT4_AT
) (
    input  logic             CLK,
    input  logic             RESET_GAME,
    note_hit_judge_if.slave  bus
);

    localparam int c_pw = SCORE_W + 1;
    localparam int c_sw = STREAK_W + 1;

    function automatic logic [2:0] mult_of(input logic [STREAK_W-1:0] s);
        if (int'(s) < MULT2_AT) begin
            return 3'd1;
        end else if (int'(s) < MULT4_AT) begin
            return 3'd2;
        end
        return 3'd4;
    endfunction

    logic [LANES-1:0]    w_press;

    judge_state_t        r_state;
    judge_state_t        w_state_next;
    logic [LANES-1:0]    r_pending;
    logic [LANES-1:0]    w_pending_next;
    logic [SCORE_W-1:0]  r_score;
    logic [SCORE_W-1:0]  w_score_next;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_next;
    logic [2:0]          r_mult;
    logic [2:0]          w_mult_next;
    logic                r_hit;
    logic                w_hit_next;
    logic                r_miss;
    logic                w_miss_next;

    logic [LANES-1:0]    w_hits;
    logic [LANES-1:0]    w_wrong;
    logic [LANES-1:0]    w_remain;
    logic [5:0]          w_hit_cnt;
    logic [2:0]          w_mult_now;
    logic [c_pw-1:0]     w_product;
    logic [c_pw-1:0]     w_sum;
    logic [SCORE_W-1:0]  w_score_sat;
    logic [c_sw-1:0]     w_streak_sum;
    logic [STREAK_W-1:0] w_streak_sat;

    key_edge_sync #(
        .WIDTH      (LANES)
    ) u_keys (
        .CLK        (CLK),
        .RESET_GAME (RESET_GAME),
        .i_key_n    (bus.KEY_N),
        .o_press    (w_press)
    );

    // With nothing pending every press is wrong, regardless of stale bits.
    assign w_hits     = (r_state == OPEN) ? (w_press & r_pending) : '0;
    assign w_wrong    = w_press & ~w_hits;
    assign w_remain   = r_pending & ~w_press;
    assign w_hit_cnt  = popcount(32'(w_hits));
    assign w_mult_now = mult_of(r_streak);

    assign w_product    = c_pw'(w_hit_cnt) * c_pw'(w_mult_now);
    assign w_sum        = {1'b0, r_score} + w_product;
    assign w_score_sat  = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
    assign w_streak_sum = {1'b0, r_streak} + c_sw'(w_hit_cnt);
    assign w_streak_sat = w_streak_sum[STREAK_W] ? '1 : w_streak_sum[STREAK_W-1:0];

    always_ff @(posedge CLK) begin
        if (RESET_GAME) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_score   <= '0;
            r_streak  <= '0;
            r_mult    <= 3'd1;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_score   <= w_score_next;
            r_streak  <= w_streak_next;
            r_mult    <= w_mult_next;
            r_hit     <= w_hit_next;
            r_miss    <= w_miss_next;
        end
    end

    always_comb begin
        w_pending_next = r_pending;
        w_score_next   = r_score;
        w_streak_next  = r_streak;
        w_hit_next     = 1'b0;
        w_miss_next    = 1'b0;

        if (bus.ENABLE) begin
            if (w_press != '0) begin
                w_pending_next = w_remain;
                w_score_next   = w_score_sat;
                w_hit_next     = |w_hits;
                if (|w_wrong) begin
                    w_streak_next = '0;
                    w_miss_next   = 1'b1;
                end else begin
                    w_streak_next = w_streak_sat;
                end
            end
            // Expiry sees the window after this cycle's presses; new notes
            // are loaded last so a simultaneous press never credits them.
            if (bus.TICK) begin
                if (|w_remain) begin
                    w_streak_next = '0;
                    w_miss_next   = 1'b1;
                end
                w_pending_next = bus.NOTE_IN;
            end
        end

        w_state_next = (w_pending_next != '0) ? OPEN : IDLE;
        w_mult_next  = mult_of(w_streak_next);
    end

    assign bus.SCORE   = r_score;
    assign bus.STREAK  = r_streak;
    assign bus.MULT    = r_mult;
    assign bus.PENDING = r_pending;
    assign bus.HIT     = r_hit;
    assign bus.MISS    = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_note_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_hit_judge
// Brief    : Scoreboard bench for note_hit_judge; a wide-score and a 4-bit-score
//            instance share stimulus so saturation is checked alongside.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_hit_judge;

    logic       CLK = 1'b0;
    logic       RESET_GAME = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] note_in = 4'b0000;
    logic [3:0] key_n = 4'b1111;
    logic       enable = 1'b1;

    always #5 CLK = ~CLK;

    note_hit_judge_if #(.LANES(4), .SCORE_W(16), .STREAK_W(8)) bus_w ();
    note_hit_judge_if #(.LANES(4), .SCORE_W(4),  .STREAK_W(8)) bus_s ();

    assign bus_w.TICK    = tick;
    assign bus_w.NOTE_IN = note_in;
    assign bus_w.KEY_N   = key_n;
    assign bus_w.ENABLE  = enable;
    assign bus_s.TICK    = tick;
    assign bus_s.NOTE_IN = note_in;
    assign bus_s.KEY_N   = key_n;
    assign bus_s.ENABLE  = enable;

    note_hit_judge #(
        .LANES(4), .SCORE_W(16), .STREAK_W(8), .MULT2_AT(8), .MULT4_AT(16)
    ) dut (
        .CLK        (CLK),
        .RESET_GAME (RESET_GAME),
        .bus        (bus_w.slave)
    );

    note_hit_judge #(
        .LANES(4), .SCORE_W(4), .STREAK_W(8), .MULT2_AT(8), .MULT4_AT(16)
    ) dut_sat (
        .CLK        (CLK),
        .RESET_GAME (RESET_GAME),
        .bus        (bus_s.slave)
    );

    typedef struct {
        logic       hit;
        logic       miss;
        int         score;
        int         streak;
        int         mult;
        logic [3:0] pending;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void expect_ev(input logic h, input logic m, input int score,
                                      input int streak, input int mult, input logic [3:0] pend);
        exp_t e;
        e.hit = h; e.miss = m; e.score = score;
        e.streak = streak; e.mult = mult; e.pending = pend;
        sb.push_back(e);
    endfunction

    // Monitor: every HIT/MISS strobe consumes one expected event.
    always @(negedge CLK) begin
        exp_t e;
        if (mon_on && (bus_w.HIT || bus_w.MISS || bus_s.HIT || bus_s.MISS)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_pulse hit=%0b miss=%0b required none", bus_w.HIT, bus_w.MISS);
            end else begin
                e = sb.pop_front();
                chk("hit",      int'(bus_w.HIT),     int'(e.hit));
                chk("miss",     int'(bus_w.MISS),    int'(e.miss));
                chk("score",    int'(bus_w.SCORE),   e.score);
                chk("streak",   int'(bus_w.STREAK),  e.streak);
                chk("mult",     int'(bus_w.MULT),    e.mult);
                chk("pending",  int'(bus_w.PENDING), int'(e.pending));
                chk("sat_hit",  int'(bus_s.HIT),     int'(e.hit));
                chk("sat_miss", int'(bus_s.MISS),    int'(e.miss));
                chk("sat_score", int'(bus_s.SCORE),  (e.score > 15) ? 15 : e.score);
            end
        end
    end

    // All tasks start and end on a falling edge.
    task automatic do_tick(input logic [3:0] n);
        tick = 1'b1; note_in = n;
        @(negedge CLK);
        tick = 1'b0; note_in = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic do_press(input logic [3:0] mask);
        key_n = key_n & ~mask;
        repeat (2) @(negedge CLK);
        key_n = key_n | mask;
        repeat (4) @(negedge CLK);
    endtask

    // Press edge reaches the judge in the same cycle as the TICK.
    task automatic press_with_tick(input logic [3:0] mask, input logic [3:0] n);
        key_n = key_n & ~mask;
        repeat (3) @(negedge CLK);
        tick = 1'b1; note_in = n;
        @(negedge CLK);
        tick = 1'b0; note_in = 4'b0000;
        key_n = key_n | mask;
        repeat (4) @(negedge CLK);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout outstanding=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        RESET_GAME = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_GAME = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int score;
        int streak;
        int m;

        repeat (3) @(negedge CLK);
        RESET_GAME = 1'b0;

        // Unchecked random activity, ending mid-window before reset.
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) do_tick(4'($urandom_range(0, 15)));
            else do_press(4'(1 << $urandom_range(0, 3)));
        end
        do_tick(4'b1111);
        do_reset();
        chk("rst_score",   int'(bus_w.SCORE),   0);
        chk("rst_streak",  int'(bus_w.STREAK),  0);
        chk("rst_mult",    int'(bus_w.MULT),    1);
        chk("rst_pending", int'(bus_w.PENDING), 0);
        chk("rst_hit",     int'(bus_w.HIT),     0);
        chk("rst_miss",    int'(bus_w.MISS),    0);
        mon_on = 1'b1;
        repeat (4) @(negedge CLK);

        // Basic hits
        do_tick(4'b0101);
        chk("load_pending", int'(bus_w.PENDING), 5);
        expect_ev(1, 0, 1, 1, 1, 4'b0100);
        do_press(4'b0001);
        expect_ev(1, 0, 2, 2, 1, 4'b0000);
        do_press(4'b0100);
        drain("basic");

        // Expiry
        do_tick(4'b1000);
        expect_ev(0, 1, 2, 0, 1, 4'b0000);
        do_tick(4'b0000);
        drain("expiry");

        // Multi-lane hit, then wrong lane with streak 5
        do_tick(4'b1111);
        expect_ev(1, 0, 6, 4, 1, 4'b0000);
        do_press(4'b1111);
        do_tick(4'b0011);
        expect_ev(1, 0, 7, 5, 1, 4'b0001);
        do_press(4'b0010);
        expect_ev(0, 1, 7, 0, 1, 4'b0001);
        do_press(4'b1000);
        drain("wrong");
        chk("wrong_pending", int'(bus_w.PENDING), 1);
        expect_ev(0, 1, 7, 0, 1, 4'b0000);
        do_tick(4'b0000);
        drain("expiry2");

        // Multiplier ladder from a clean reset: 17 consecutive single hits
        do_reset();
        score = 0;
        streak = 0;
        for (int k = 0; k < 17; k++) begin
            m = (streak < 8) ? 1 : (streak < 16) ? 2 : 4;
            score = score + m;
            streak = streak + 1;
            do_tick(4'b0001);
            expect_ev(1, 0, score, streak, (streak < 8) ? 1 : (streak < 16) ? 2 : 4, 4'b0000);
            do_press(4'b0001);
        end
        drain("mult");
        chk("ladder_score",  int'(bus_w.SCORE),  28);
        chk("ladder_streak", int'(bus_w.STREAK), 17);
        chk("ladder_mult",   int'(bus_w.MULT),   4);
        chk("ladder_sat",    int'(bus_s.SCORE),  15);

        // Press on the TICK cycle credits the old window only
        do_tick(4'b0010);
        expect_ev(1, 0, 32, 18, 4, 4'b0010);
        press_with_tick(4'b0010, 4'b0010);
        drain("simul");
        chk("simul_pending", int'(bus_w.PENDING), 2);

        // Disabled: identical stimulus changes nothing
        enable = 1'b0;
        press_with_tick(4'b0010, 4'b0100);
        chk("dis_score",   int'(bus_w.SCORE),   32);
        chk("dis_streak",  int'(bus_w.STREAK),  18);
        chk("dis_pending", int'(bus_w.PENDING), 2);

        // Button held across re-enable yields no stale press
        key_n = 4'b1101;
        repeat (6) @(negedge CLK);
        enable = 1'b1;
        repeat (6) @(negedge CLK);
        chk("held_pending", int'(bus_w.PENDING), 2);
        chk("held_streak",  int'(bus_w.STREAK),  18);
        key_n = 4'b1111;
        repeat (4) @(negedge CLK);
        expect_ev(1, 0, 36, 19, 4, 4'b0000);
        do_press(4'b0010);
        drain("reenable");

        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog elapsed=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/note_hit_judge.md
Name: note_hit_judge

Overview:
Consumer end of the note track. It takes the strike-zone row the shift-register track delivers on each game tick and judges the player's lane buttons against it. Output is hit/miss strobes, a running streak, a multiplier and a saturating score. It sits between the bottom track stage plus the DE2 KEY pins and the score/LEDG display logic.

Parameters:
LANES, 4, number of note lanes / buttons
SCORE_W, 16, score register width
STREAK_W, 8, streak counter width
MULT2_AT, 8, streak at which multiplier becomes 2
MULT4_AT, 16, streak at which multiplier becomes 4

Ports:
CLK  in  1  system clock (CLOCK_50 domain)
RESET_GAME  in  1  synchronous, active-high reset
TICK  in  1  one-cycle strobe, CLK-synchronous; track advanced, NOTE_IN valid this cycle
NOTE_IN  in  LANES  strike-row lane bits, sampled only on TICK
KEY_N  in  LANES  raw active-low lane buttons, asynchronous
ENABLE  in  1  game running; 0 freezes judging
SCORE  out  SCORE_W  accumulated score
STREAK  out  STREAK_W  consecutive hit-lane count
MULT  out  3  current multiplier: 1, 2 or 4
PENDING  out  LANES  lanes still awaiting a press in the current window
HIT  out  1  one-cycle pulse, at least one lane hit
MISS  out  1  one-cycle pulse, note expired or wrong lane pressed

Behaviour:
- Reset state: all outputs are 0 except MULT=1. Sync flops are 0 (released). FSM is IDLE. Reset mid-window drops PENDING without a MISS.
- Key conditioning, per lane: 2-flop synchronizer on ~KEY_N, then rising-edge detect gives press vector P. The pin-to-P latency is 3 CLK.
- FSM states: IDLE (PENDING==0) and OPEN (PENDING!=0). The state is derived from PENDING after every update.
- Press evaluation happens on any cycle with ENABLE=1 and P!=0:
  - hits = P & PENDING; wrong = P & ~PENDING.
  - PENDING <= PENDING & ~P.
  - The multiplier m is taken from STREAK before the update: STREAK<MULT2_AT gives 1; STREAK<MULT4_AT gives 2; otherwise 4.
  - SCORE += popcount(hits)*m, saturating at all-ones.
  - If wrong!=0, STREAK <= 0 and hits score but add no streak. Otherwise STREAK += popcount(hits), saturating.
  - In IDLE every press is wrong.
- TICK with ENABLE=1 proceeds in this order within one cycle:
  - (a) Presses in P are evaluated against the old PENDING.
  - (b) Any old-PENDING bits left after (a) are expired: STREAK <= 0, MISS, no score change.
  - (c) PENDING <= NOTE_IN. Presses are never credited to the notes just loaded.
- HIT and MISS are registered and pulse one CLK after the event cycle. Both may pulse in the same cycle. Multiple events in one cycle still produce a single pulse each.
- MULT is registered from the updated STREAK.
- ENABLE=0 behaviour:
  - TICK and P are ignored; SCORE, STREAK and PENDING hold.
  - The synchronizer and edge detector keep running, so a button held across re-enable gives no stale press.
- Arithmetic: popcount is at most LANES. The product is computed at width SCORE_W+1 before saturation.

Decomposition:
- Shared package gh_pkg holds:
  - LANES, SCORE_W, STREAK_W
  - MULT2_AT, MULT4_AT
  - the judge_state_t enum {IDLE, OPEN}
  - a popcount function
- Sub-module key_edge_sync: a parameterised LANES-wide 2-flop synchronizer plus rising-edge detector, with CLK and RESET_GAME ports. It is reusable for the menu/reset buttons.

Test Plan:
- Reset: RESET_GAME=1 for 2 cycles after random activity -> SCORE=0, STREAK=0, MULT=1, PENDING=0, HIT=MISS=0.
- Basic hits: TICK with NOTE_IN=0101, then drop KEY_N[0] -> 3 cycles later PENDING=0100, then HIT, SCORE=1. Then drop KEY_N[2] -> SCORE=2, STREAK=2, PENDING=0000 (IDLE).
- Expiry: TICK NOTE_IN=1000, no press, next TICK NOTE_IN=0000 -> MISS pulse one cycle later, STREAK=0, SCORE unchanged.
- Wrong lane: PENDING=0001 with STREAK=5, press lane 3 -> MISS, STREAK=0, PENDING stays 0001, SCORE unchanged.
- Multiplier: 8 consecutive single hits -> STREAK=8, MULT=2; 9th hit -> SCORE=10. Continue to STREAK=16 -> MULT=4; next hit adds 4. Separate run with SCORE_W=4 -> SCORE saturates at 15.
- Simultaneous: old PENDING=0010, press lane 1 edge on the same cycle as TICK with NOTE_IN=0010 -> HIT only, no MISS, PENDING=0010 (new window). With ENABLE=0, the same stimulus -> no change.
